// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 4-bit combinational ALU. It takes one command over valid/ready, holds the ALU inputs
// for SETTLE_CYCLES clocks, then captures ALUout and returns it over a valid/ready response.
module alu_cmd_sequencer #(
   parameter int DATA_W        = 4,
   parameter int RES_W         = 8,
   parameter int FUNC_W        = 3,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [FUNC_W-1:0] cmd_func,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_use_acc,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [RES_W-1:0]  alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_data,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [RES_W-1:0]  acc,
   output logic              busy
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [FUNC_W-1:0] FUNC_BAD0 = FUNC_W'(6);
   localparam logic [FUNC_W-1:0] FUNC_BAD1 = FUNC_W'(7);

   generate
      if (RES_W != 2 * DATA_W) begin : g_bad_width
         $error("alu_cmd_sequencer: RES_W must equal 2*DATA_W");
      end
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("alu_cmd_sequencer: SETTLE_CYCLES must be 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] settle_cnt;
   logic             accept;
   logic             capture;
   logic             func_bad;

   assign accept   = (state == IDLE) && cmd_valid;
   assign capture  = (state == SETTLE) && (settle_cnt == CNT_LAST);
   assign func_bad = (alu_func == FUNC_BAD0) || (alu_func == FUNC_BAD1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = SETTLE;
         SETTLE:  if (capture)   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
   end

   // ALU inputs and the response hold their values outside the transaction edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         settle_cnt <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_func   <= '0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         acc        <= '0;
      end else begin
         if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_use_acc ? acc[DATA_W-1:0] : cmd_b;
            alu_func   <= cmd_func;
            settle_cnt <= '0;
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
         end

         if (capture) begin
            if (func_bad) begin
               rsp_data <= '0;
               rsp_zero <= 1'b1;
               rsp_err  <= 1'b1;
            end else begin
               rsp_data <= alu_result;
               rsp_zero <= (alu_result == '0);
               rsp_err  <= 1'b0;
               acc      <= alu_result;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: three instances (settle 1, 4, 15), each with a behavioural ALU.
module tb_alu_cmd_sequencer;

   localparam int D1  = 0;
   localparam int D4  = 1;
   localparam int D15 = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] cmd_func;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       cmd_use_acc;

   logic       cmd_valid  [3];
   logic       rsp_ready  [3];
   logic       cmd_ready  [3];
   logic [3:0] alu_a      [3];
   logic [3:0] alu_b      [3];
   logic [2:0] alu_func   [3];
   logic [7:0] alu_result [3];
   logic       rsp_valid  [3];
   logic [7:0] rsp_data   [3];
   logic       rsp_zero   [3];
   logic       rsp_err    [3];
   logic [7:0] acc        [3];
   logic       busy       [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Team ALU: 000 add, 001 sub, 010 negate B, 011 and, 100 signed mul, 101 concat; 11x drives junk.
   function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
      logic signed [7:0] sa;
      logic signed [7:0] sb;
      sa = 8'(signed'(a));
      sb = 8'(signed'(b));
      case (f)
         3'b000:  return {4'h0, a} + {4'h0, b};
         3'b001:  return {4'h0, a} - {4'h0, b};
         3'b010:  return 8'h00 - {4'h0, b};
         3'b011:  return {4'h0, a & b};
         3'b100:  return 8'(sa * sb);
         3'b101:  return {a, b};
         default: return 8'hAA;
      endcase
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      assign alu_result[gi] = alu_model(alu_a[gi], alu_b[gi], alu_func[gi]);
      alu_cmd_sequencer #(
         .DATA_W(4), .RES_W(8), .FUNC_W(3),
         .SETTLE_CYCLES((gi == 0) ? 1 : (gi == 1) ? 4 : 15)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .cmd_valid  (cmd_valid[gi]),
         .cmd_ready  (cmd_ready[gi]),
         .cmd_func   (cmd_func),
         .cmd_a      (cmd_a),
         .cmd_b      (cmd_b),
         .cmd_use_acc(cmd_use_acc),
         .alu_a      (alu_a[gi]),
         .alu_b      (alu_b[gi]),
         .alu_func   (alu_func[gi]),
         .alu_result (alu_result[gi]),
         .rsp_valid  (rsp_valid[gi]),
         .rsp_ready  (rsp_ready[gi]),
         .rsp_data   (rsp_data[gi]),
         .rsp_zero   (rsp_zero[gi]),
         .rsp_err    (rsp_err[gi]),
         .acc        (acc[gi]),
         .busy       (busy[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command, wait for acceptance, and return edges from accept to rsp_valid.
   task automatic do_cmd(input int i, input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                         input logic ua, output int lat);
      int n;
      cmd_func = f; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
      cmd_valid[i] = 1'b1;
      n = 0;
      while (!cmd_ready[i] && n < 50) begin tick(); n++; end
      if (n >= 50) check("accept_timeout", 0, 1);
      tick();
      cmd_valid[i] = 1'b0;
      lat = 0;
      while (!rsp_valid[i] && lat < 40) begin tick(); lat++; end
      if (lat >= 40) check("rsp_timeout", 0, 1);
   endtask

   task automatic ack(input int i);
      rsp_ready[i] = 1'b1;
      tick();
      rsp_ready[i] = 1'b0;
      check("ack_rsp_valid", rsp_valid[i], 0);
      check("ack_cmd_ready", cmd_ready[i], 1);
   endtask

   initial begin
      int lat;
      int pulses;
      reset = 1'b1;
      cmd_func = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid[i] = 1'b0;
         rsp_ready[i] = 1'b0;
      end
      tick(); tick();
      reset = 1'b0;

      check("rst_cmd_ready", cmd_ready[D1], 1);
      check("rst_rsp_valid", rsp_valid[D1], 0);
      check("rst_busy",      busy[D1],      0);
      check("rst_acc",       acc[D1],       0);
      check("rst_alu_a",     alu_a[D1],     0);
      check("rst_rsp_data",  rsp_data[D1],  0);

      // T1: F + 1 with one settle cycle
      do_cmd(D1, 3'b000, 4'hF, 4'h1, 1'b0, lat);
      check("t1_latency",  lat,            1);
      check("t1_alu_a",    alu_a[D1],      4'hF);
      check("t1_alu_b",    alu_b[D1],      4'h1);
      check("t1_busy",     busy[D1],       1);
      check("t1_data",     rsp_data[D1],   8'h10);
      check("t1_zero",     rsp_zero[D1],   0);
      check("t1_err",      rsp_err[D1],    0);
      check("t1_acc",      acc[D1],        8'h10);
      ack(D1);

      // T2: concat, then chain acc low nibble as B
      do_cmd(D1, 3'b101, 4'h3, 4'h5, 1'b0, lat);
      check("t2a_data", rsp_data[D1], 8'h35);
      ack(D1);
      do_cmd(D1, 3'b000, 4'h1, 4'hC, 1'b1, lat);
      check("t2b_alu_b", alu_b[D1],    4'h5);
      check("t2b_data",  rsp_data[D1], 8'h06);
      check("t2b_acc",   acc[D1],      8'h06);
      ack(D1);

      // T3: negate B, then an unsupported function
      do_cmd(D1, 3'b010, 4'h0, 4'h8, 1'b0, lat);
      check("t3a_data", rsp_data[D1], 8'hF8);
      ack(D1);
      do_cmd(D1, 3'b110, 4'h2, 4'h3, 1'b0, lat);
      check("t3b_err",  rsp_err[D1],  1);
      check("t3b_data", rsp_data[D1], 8'h00);
      check("t3b_zero", rsp_zero[D1], 1);
      check("t3b_acc",  acc[D1],      8'hF8);
      ack(D1);
      do_cmd(D1, 3'b000, 4'h0, 4'h0, 1'b0, lat);
      check("zero_res_zero", rsp_zero[D1], 1);
      check("zero_res_err",  rsp_err[D1],  0);
      ack(D1);

      // T4: backpressure with a second command pending the whole time
      do_cmd(D1, 3'b000, 4'h2, 4'h3, 1'b0, lat);
      cmd_func = 3'b101; cmd_a = 4'h9; cmd_b = 4'hA; cmd_use_acc = 1'b0;
      cmd_valid[D1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t4_rsp_valid", rsp_valid[D1], 1);
         check("t4_rsp_data",  rsp_data[D1],  8'h05);
         check("t4_cmd_ready", cmd_ready[D1], 0);
         check("t4_alu_a",     alu_a[D1],     4'h2);
      end
      rsp_ready[D1] = 1'b1;
      tick();
      rsp_ready[D1] = 1'b0;
      check("t4_idle_ready", cmd_ready[D1], 1);
      check("t4_alu_a_held", alu_a[D1],     4'h2);
      tick();
      cmd_valid[D1] = 1'b0;
      check("t4_second_alu_a", alu_a[D1], 4'h9);
      tick();
      check("t4_second_data", rsp_data[D1], 8'h9A);
      check("t4_second_valid", rsp_valid[D1], 1);
      ack(D1);

      // T5: reset in the middle of SETTLE on the 4-cycle instance
      do_cmd(D4, 3'b000, 4'h3, 4'h4, 1'b0, lat);
      check("t5a_latency", lat,           4);
      check("t5a_data",    rsp_data[D4],  8'h07);
      ack(D4);
      cmd_func = 3'b101; cmd_a = 4'h1; cmd_b = 4'h2;
      cmd_valid[D4] = 1'b1;
      tick();
      cmd_valid[D4] = 1'b0;
      tick();
      check("t5_in_settle", busy[D4], 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_rst_busy",  busy[D4],      0);
      check("t5_rst_ready", cmd_ready[D4], 1);
      check("t5_rst_valid", rsp_valid[D4], 0);
      check("t5_rst_acc",   acc[D4],       0);
      check("t5_rst_alu_a", alu_a[D4],     0);
      check("t5_rst_data",  rsp_data[D4],  0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (rsp_valid[D4]) pulses++;
      end
      check("t5_no_rsp", pulses, 0);
      do_cmd(D4, 3'b000, 4'h2, 4'h2, 1'b0, lat);
      check("t5b_latency", lat,          4);
      check("t5b_data",    rsp_data[D4], 8'h04);
      ack(D4);

      // T6: signed multiply with a 15-cycle settle
      do_cmd(D15, 3'b100, 4'hF, 4'hF, 1'b0, lat);
      check("t6_latency", lat,           15);
      check("t6_data",    rsp_data[D15], 8'h01);
      check("t6_acc",     acc[D15],      8'h01);
      ack(D15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
